// File: rtl/addsub_pkg.sv
// Shared types and constants for the adder/subtractor result stage.
// Saturation constants are used only when ADDSUB_SAT_EN is defined.
package addsub_pkg;

   localparam int unsigned WIDTH = 16;

   localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
   localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             carry;
      logic             ovf;
      logic             zero;
      logic             neg;
   } addsub_entry_t;

endpackage

// File: rtl/addsub_flag_calc.sv
// Combinational status-flag derivation for one adder/subtractor result.
// Optional feature macro: ADDSUB_SAT_EN (saturate the stored result on overflow).
module addsub_flag_calc
   import addsub_pkg::*;
(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_cout,
   output addsub_entry_t    o_entry
);

   logic             w_a_msb;
   logic             w_b_msb;
   logic             w_s_msb;
   logic             w_ovf;
   logic             w_carry;
   logic [WIDTH-1:0] w_result;

   assign w_a_msb = i_a[WIDTH-1];
   assign w_b_msb = i_b[WIDTH-1];
   assign w_s_msb = i_sum[WIDTH-1];

   // Subtract flips the sign of b, so the "same sign" test inverts with mode.
   assign w_ovf   = i_mode ? ((w_a_msb != w_b_msb) && (w_s_msb != w_a_msb))
                           : ((w_a_msb == w_b_msb) && (w_s_msb != w_a_msb));
   assign w_carry = i_mode ? ~i_cout : i_cout;

`ifdef ADDSUB_SAT_EN
   assign w_result = w_ovf ? (w_a_msb ? SAT_NEG : SAT_POS) : i_sum;
`else
   assign w_result = i_sum;
`endif

   // Pack the final result and its flags into one FIFO entry.
   always_comb begin
      o_entry        = '0;
      o_entry.result = w_result;
      o_entry.carry  = w_carry;
      o_entry.ovf    = w_ovf;
      o_entry.zero   = (w_result == '0);
      o_entry.neg    = w_result[WIDTH-1];
   end

endmodule

// File: rtl/addsub_result_stage.sv
// Result stage behind the 16-bit adder/subtractor: flag derivation, 2-entry
// skid FIFO with valid/ready, transfer counter and sticky overflow flag.
// Optional feature macro: ADDSUB_SAT_EN (handled in addsub_flag_calc).
module addsub_result_stage #(
   parameter int unsigned WIDTH   = addsub_pkg::WIDTH,
   parameter int unsigned COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_mode,
   input  logic [WIDTH-1:0]   in_sum,
   input  logic               in_cout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic               out_carry,
   output logic               out_ovf,
   output logic               out_zero,
   output logic               out_neg,
   output logic               ovf_sticky,
   input  logic               clr_sticky,
   output logic [COUNT_W-1:0] op_count
);

   import addsub_pkg::*;

   addsub_entry_t      w_new_entry;
   addsub_entry_t      r_slot0;
   addsub_entry_t      r_slot1;
   logic [1:0]         r_count;
   logic               w_push;
   logic               w_pop;
   logic [COUNT_W-1:0] r_op_count;
   logic               r_ovf_sticky;

   addsub_flag_calc u_flag_calc (
      .i_a     (in_a),
      .i_b     (in_b),
      .i_mode  (in_mode),
      .i_sum   (in_sum),
      .i_cout  (in_cout),
      .o_entry (w_new_entry)
   );

   assign in_ready  = (r_count < 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign out_result = r_slot0.result;
   assign out_carry  = r_slot0.carry;
   assign out_ovf    = r_slot0.ovf;
   assign out_zero   = r_slot0.zero;
   assign out_neg    = r_slot0.neg;
   assign ovf_sticky = r_ovf_sticky;
   assign op_count   = r_op_count;

   // FIFO storage: slot0 is always the head, slot1 the tail when two are held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 2'd0;
         r_slot0 <= '0;
         r_slot1 <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_slot0 <= w_new_entry;
               else                 r_slot1 <= w_new_entry;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_slot0 <= r_slot1;
               r_count <= r_count - 2'd1;
            end
            // Push with pop can only happen at count 1: new entry replaces the head.
            2'b11:   r_slot0 <= w_new_entry;
            default: ;
         endcase
      end
   end

   // Completed-transfer counter, wraps naturally at 2^COUNT_W.
   always_ff @(posedge clk) begin
      if (rst)        r_op_count <= '0;
      else if (w_pop) r_op_count <= r_op_count + 1'b1;
   end

   // Sticky overflow: a new overflowing entry takes priority over a clear.
   always_ff @(posedge clk) begin
      if (rst)                          r_ovf_sticky <= 1'b0;
      else if (w_push && w_new_entry.ovf) r_ovf_sticky <= 1'b1;
      else if (clr_sticky)              r_ovf_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Self-checking bench for addsub_result_stage: directed scenarios plus random
// traffic, compared against an arithmetic reference model and a queue.
// Honours ADDSUB_SAT_EN in the reference model.
module tb_addsub_result_stage;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_mode;
   logic [W-1:0]  in_sum;
   logic          in_cout;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic          out_carry;
   logic          out_ovf;
   logic          out_zero;
   logic          out_neg;
   logic          ovf_sticky;
   logic          clr_sticky;
   logic [CW-1:0] op_count;

   addsub_result_stage #(.WIDTH(W), .COUNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_mode    (in_mode),
      .in_sum     (in_sum),
      .in_cout    (in_cout),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_carry  (out_carry),
      .out_ovf    (out_ovf),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .ovf_sticky (ovf_sticky),
      .clr_sticky (clr_sticky),
      .op_count   (op_count)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic        carry;
      logic        ovf;
      logic        zero;
      logic        neg;
   } exp_t;

   exp_t        q[$];
   int unsigned m_ops;
   logic        m_sticky;
   logic        last_push;
   int          n_tests;
   int          n_fail;
   int unsigned ops0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected entry from true signed/unsigned arithmetic on the operands.
   function automatic exp_t ref_entry(input logic [15:0] a, input logic [15:0] b,
                                      input logic mode);
      int   sa;
      int   sb;
      int   ex;
      exp_t e;
      sa      = $signed(a);
      sb      = $signed(b);
      ex      = mode ? (sa - sb) : (sa + sb);
      e.ovf   = (ex > 32767) || (ex < -32768);
      e.carry = mode ? (a < b) : ((int'(a) + int'(b)) > 65535);
      e.res   = ex[15:0];
`ifdef ADDSUB_SAT_EN
      if (e.ovf) e.res = (ex > 0) ? 16'h7FFF : 16'h8000;
`endif
      e.zero  = (e.res == 16'h0000);
      e.neg   = e.res[15];
      return e;
   endfunction

   // Apply operands and the upstream adder's sum/cout for them.
   task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic mode);
      logic [16:0] full;
      in_a    = a;
      in_b    = b;
      in_mode = mode;
      if (mode) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
      else      full = {1'b0, a} + {1'b0, b};
      in_sum  = full[15:0];
      in_cout = full[16];
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h0001;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         4:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic check_state();
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("result", 32'(out_result), 32'(q[0].res));
         chk("carry", 32'(out_carry), 32'(q[0].carry));
         chk("ovf", 32'(out_ovf), 32'(q[0].ovf));
         chk("zero", 32'(out_zero), 32'(q[0].zero));
         chk("neg", 32'(out_neg), 32'(q[0].neg));
      end
      chk("op_count", 32'(op_count), m_ops % 256);
      chk("sticky", 32'(ovf_sticky), 32'(m_sticky));
   endtask

   // One clock: decide transfers from the model, advance it, then compare.
   task automatic cycle();
      bit   push;
      bit   pop;
      exp_t e;
      push = !rst && in_valid && (q.size() < 2);
      pop  = !rst && out_ready && (q.size() > 0);
      e    = ref_entry(in_a, in_b, in_mode);
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         m_ops    = 0;
         m_sticky = 1'b0;
      end else begin
         if (pop) begin
            void'(q.pop_front());
            m_ops++;
         end
         if (push) q.push_back(e);
         if (push && e.ovf) m_sticky = 1'b1;
         else if (clr_sticky) m_sticky = 1'b0;
      end
      last_push = push;
      check_state();
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      m_ops      = 0;
      m_sticky   = 1'b0;
      last_push  = 1'b0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
      drive_op(16'h0000, 16'h0000, 1'b0);
      cycle();
      cycle();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", 32'(out_result), 32'd0);
      chk("rst_flags", 32'({out_carry, out_ovf, out_zero, out_neg}), 32'd0);
      chk("rst_opcnt", 32'(op_count), 32'd0);
      rst = 1'b0;

      // Add 3 + 4
      out_ready = 1'b1;
      in_valid  = 1'b1;
      drive_op(16'h0003, 16'h0004, 1'b0);
      cycle();
      in_valid = 1'b0;
      chk("add_result", 32'(out_result), 32'h0007);
      chk("add_flags", 32'({out_carry, out_ovf, out_zero, out_neg}), 32'd0);
      cycle();
      chk("add_opcnt", 32'(op_count), 32'd1);

      // Subtract: zero result, then borrow with negative result
      in_valid = 1'b1;
      drive_op(16'h0005, 16'h0005, 1'b1);
      cycle();
      chk("sub_zero", 32'(out_zero), 32'd1);
      chk("sub_noborrow", 32'(out_carry), 32'd0);
      drive_op(16'h0000, 16'h0001, 1'b1);
      cycle();
      chk("sub_borrow", 32'(out_carry), 32'd1);
      chk("sub_neg", 32'(out_neg), 32'd1);
      in_valid = 1'b0;
      cycle();

      // Overflow, then clear together with a new overflow
      in_valid = 1'b1;
      drive_op(16'h7FFF, 16'h0001, 1'b0);
      cycle();
      chk("ovf_flag", 32'(out_ovf), 32'd1);
      chk("ovf_sticky", 32'(ovf_sticky), 32'd1);
`ifdef ADDSUB_SAT_EN
      chk("ovf_result", 32'(out_result), 32'h7FFF);
`else
      chk("ovf_result", 32'(out_result), 32'h8000);
`endif
      clr_sticky = 1'b1;
      drive_op(16'h8000, 16'h8000, 1'b0);
      cycle();
      chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
      in_valid = 1'b0;
      cycle();
      chk("sticky_cleared", 32'(ovf_sticky), 32'd0);
      clr_sticky = 1'b0;

      // Stalled consumer: third entry held while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_op(16'd11, 16'd1, 1'b0);
      cycle();
      drive_op(16'd22, 16'd1, 1'b0);
      cycle();
      chk("full_ready", 32'(in_ready), 32'd0);
      drive_op(16'd33, 16'd1, 1'b0);
      repeat (3) cycle();
      chk("stall_head", 32'(out_result), 32'd12);
      out_ready = 1'b1;
      cycle();
      chk("drain_second", 32'(out_result), 32'd23);
      cycle();
      chk("third_accepted", 32'(last_push), 32'd1);
      in_valid = 1'b0;
      chk("drain_third", 32'(out_result), 32'd34);
      cycle();

      // Steady state at count 1 with push and pop every cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_op(pick(), pick(), 1'($urandom_range(0, 1)));
      cycle();
      ops0      = m_ops;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_op(pick(), pick(), 1'($urandom_range(0, 1)));
         cycle();
         chk("steady_ready", 32'(in_ready), 32'd1);
      end
      chk("steady_ops", 32'(op_count), (ops0 + 10) % 256);
      in_valid = 1'b0;
      cycle();

      // Reset with two entries buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_op(16'h7FFF, 16'h0001, 1'b0);
      cycle();
      drive_op(16'h1234, 16'h0001, 1'b0);
      cycle();
      in_valid = 1'b0;
      rst      = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_opcnt", 32'(op_count), 32'd0);
      chk("midrst_sticky", 32'(ovf_sticky), 32'd0);

      // 256 transfers wrap the counter
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 700 && m_ops < 256; i++) begin
         drive_op(pick(), pick(), 1'($urandom_range(0, 1)));
         cycle();
      end
      chk("opcnt_wrap", 32'(op_count), 32'd0);
      in_valid = 1'b0;
      cycle();
      cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid   = 1'($urandom_range(0, 1));
         out_ready  = 1'($urandom_range(0, 1));
         clr_sticky = ($urandom_range(0, 7) == 0);
         drive_op(pick(), pick(), 1'($urandom_range(0, 1)));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Downstream stage of the 16-bit structural adder/subtractor. Captures the adder's combinational result (sum, cout) together with the operands and mode that produced it.
- Derives status flags: carry/borrow, signed overflow, zero and negative.
- Buffers results in a 2-entry skid FIFO behind a valid/ready handshake.
- Keeps a transfer counter and a sticky overflow flag for the consuming datapath/controller.

Parameters:
- WIDTH, 16, datapath width; must match the adder.
- COUNT_W, 8, width of the output transfer counter.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream presents a valid adder result this cycle.
- in_ready  out  1  stage can accept the entry.
- in_a  in  WIDTH  operand a as applied to the adder.
- in_b  in  WIDTH  operand b as applied to the adder (before mode inversion).
- in_mode  in  1  0 = add, 1 = subtract.
- in_sum  in  WIDTH  adder sum output.
- in_cout  in  1  adder carry out.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry.
- out_result  out  WIDTH  result value.
- out_carry  out  1  add: carry out; sub: borrow (= ~cout).
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].
- ovf_sticky  out  1  set by any accepted entry with ovf; held until cleared.
- clr_sticky  in  1  clears ovf_sticky.
- op_count  out  COUNT_W  number of completed output transfers, modulo 2^COUNT_W.

Behaviour:
- Reset: FIFO count=0; out_valid=0; in_ready=1; out_result/flags=0; ovf_sticky=0; op_count=0. Reset mid-operation discards all buffered entries.
- Accept: in_valid & in_ready.
- Flags are computed combinationally at accept and stored in the entry:
  - add overflow: a[15]==b[15] && sum[15]!=a[15].
  - sub overflow: a[15]!=b[15] && sum[15]!=a[15].
  - carry: add -> cout; sub -> ~cout.
  - zero/neg: computed on the final stored result.
- Latency: an entry accepted into an empty FIFO appears on out_valid the next cycle. No combinational path from in_* to out_*.
- in_ready = (count < 2). It depends on registered count only, never on out_ready.
- Pop: out_valid & out_ready.
- count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together at count=1: stays 1, ordering preserved (head pops, new entry becomes head).
  - push at count=2 is impossible because in_ready=0.
  - pop at count=0 is impossible because out_valid=0.
- Entries leave strictly in FIFO order. Head outputs are stable while out_valid=1 and out_ready=0.
- op_count increments on each pop and wraps from 2^COUNT_W-1 to 0.
- ovf_sticky:
  - set when an accepted entry has ovf=1;
  - cleared by clr_sticky;
  - if both happen in the same cycle, set wins.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: when ovf=1, the stored result saturates to 0x7FFF if a[15]=0, or to 0x8000 if a[15]=1. out_ovf still reports 1. zero/neg reflect the saturated value.
- Undefined: the stored result is always the wrapped in_sum.

Decomposition:
- Package addsub_pkg holds:
  - WIDTH constant (16);
  - SAT_POS (0x7FFF) and SAT_NEG (0x8000);
  - packed struct addsub_entry_t {result, carry, ovf, zero, neg}.
- Sub-module addsub_flag_calc: purely combinational. Takes a, b, mode, sum, cout and produces an addsub_entry_t, including saturation under ADDSUB_SAT_EN.
- The FIFO, counter and sticky logic stay in the top module.

Test Plan:
- Add 0x0003+0x0004 (sum 0x0007, cout 0), out_ready=1 -> next cycle out_result=0x0007, carry=0, ovf=0, zero=0, neg=0; op_count=1.
- Sub 0x0005-0x0005 (sum 0x0000, cout 1) -> result 0x0000, carry(borrow)=0, zero=1. Sub 0x0000-0x0001 (sum 0xFFFF, cout 0) -> borrow=1, neg=1.
- Add 0x7FFF+0x0001 (sum 0x8000) -> ovf=1, ovf_sticky=1; result 0x8000 without ADDSUB_SAT_EN, 0x7FFF with it. clr_sticky and a new overflow in the same cycle -> sticky stays 1.
- out_ready=0, push 3 entries back-to-back -> in_ready drops after 2nd accept; 3rd held. Then out_ready=1 -> all three emerge in order, head stable while stalled.
- count=1 with simultaneous push and pop for 10 cycles -> count stays 1, in_ready stays 1, results in order; op_count advances by 10.
- Assert rst with 2 entries buffered -> next cycle out_valid=0, in_ready=1, op_count=0, ovf_sticky=0. Run 256 transfers with COUNT_W=8 -> op_count wraps to 0.
